// File: rtl/sensor_debounce_pkg.sv
// Shared types and constants for the sensor debouncer: FSM state encoding,
// Avalon-MM word addresses and STATUS register bit positions.
package sensor_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_STATUS     = 2'd0;
    localparam logic [1:0] ADDR_DEBOUNCE   = 2'd1;
    localparam logic [1:0] ADDR_RISE_CNT   = 2'd2;
    localparam logic [1:0] ADDR_GLITCH_CNT = 2'd3;

    localparam int STAT_CLEAN_BIT = 0;
    localparam int STAT_SYNC_BIT  = 1;
    localparam int STAT_STATE_LSB = 2;
    localparam int STAT_STATE_MSB = 3;

    localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == STAT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// Parameterised multi-flop synchronizer for an asynchronous single-bit input.
// Legal STAGES range is 2..4.
module sensor_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sensor_debounce.sv
// Debounces an external sensor pin and exposes status/statistics over Avalon-MM.
// Define SENSOR_GLITCH_STATS_EN to build the glitch counter at word address 3.
module sensor_debounce
    import sensor_debounce_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_W       = 16,
    parameter int DEFAULT_DEBOUNCE = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sensor_raw,
    output logic        sensor_clean
);

    logic                  sync_q;
    state_t                state;
    logic [DEBOUNCE_W-1:0] cnt;
    logic [DEBOUNCE_W-1:0] debounce_q;
    logic [DEBOUNCE_W-1:0] last_cnt;
    logic [15:0]           rise_cnt;
    logic                  wr_en;
    logic                  wr_dbn;
    logic                  in_check;
    logic                  abort;
    logic                  rise_evt;
    logic [31:0]           rd_next;
    logic                  unused_wdata;

    sensor_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_raw),
        .q     (sync_q)
    );

    assign wr_en        = chipselect & ~write_n;
    assign wr_dbn       = wr_en && (address == ADDR_DEBOUNCE);
    assign in_check     = (state == CHK_HI) || (state == CHK_LO);
    assign abort        = wr_dbn && in_check;
    assign unused_wdata = ^writedata;

    // A debounce value of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign last_cnt = (debounce_q == '0) ? '0 : debounce_q - DEBOUNCE_W'(1);

    assign rise_evt = !abort && (state == CHK_HI) && sync_q && (cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= STABLE_LO;
            cnt          <= '0;
            sensor_clean <= 1'b0;
        end else if (abort) begin
            // Retuning the window mid-check restarts qualification from scratch.
            if (state == CHK_HI) state <= STABLE_LO;
            else                 state <= STABLE_HI;
            cnt <= '0;
        end else begin
            case (state)
                STABLE_LO: begin
                    if (sync_q) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!sync_q) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == last_cnt) begin
                        state        <= STABLE_HI;
                        sensor_clean <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + DEBOUNCE_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync_q) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (sync_q) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == last_cnt) begin
                        state        <= STABLE_LO;
                        sensor_clean <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + DEBOUNCE_W'(1);
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            debounce_q <= DEBOUNCE_W'(DEFAULT_DEBOUNCE);
        end else if (wr_dbn) begin
            debounce_q <= writedata[DEBOUNCE_W-1:0];
        end
    end

    // Clear-on-write takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_cnt <= '0;
        end else if (wr_en && (address == ADDR_RISE_CNT)) begin
            rise_cnt <= '0;
        end else if (rise_evt) begin
            rise_cnt <= sat_inc(rise_cnt);
        end
    end

`ifdef SENSOR_GLITCH_STATS_EN
    logic [15:0] glitch_cnt;
    logic        glitch_evt;

    assign glitch_evt = !abort &&
                        (((state == CHK_HI) && !sync_q) || ((state == CHK_LO) && sync_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (wr_en && (address == ADDR_GLITCH_CNT)) begin
            glitch_cnt <= '0;
        end else if (glitch_evt) begin
            glitch_cnt <= sat_inc(glitch_cnt);
        end
    end
`endif

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_STATUS: begin
                rd_next[STAT_CLEAN_BIT]                = sensor_clean;
                rd_next[STAT_SYNC_BIT]                 = sync_q;
                rd_next[STAT_STATE_MSB:STAT_STATE_LSB] = state;
            end
            ADDR_DEBOUNCE: rd_next[DEBOUNCE_W-1:0] = debounce_q;
            ADDR_RISE_CNT: rd_next[15:0]           = rise_cnt;
`ifdef SENSOR_GLITCH_STATS_EN
            ADDR_GLITCH_CNT: rd_next[15:0]         = glitch_cnt;
`endif
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce: directed scenarios plus a randomized
// run, all compared against a run-length reference model of the debounce rules.
module tb_sensor_debounce;

    localparam int S       = 2;
    localparam int DEF_DBN = 1000;
`ifdef SENSOR_GLITCH_STATS_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        sensor_raw = 1'b0;
    logic        sensor_clean;

    int checks = 0;
    int errors = 0;

    sensor_debounce dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .sensor_raw   (sensor_raw),
        .sensor_clean (sensor_clean)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Reference model: a delay line for the synchronizer, and a run length of
    // consecutive samples that disagree with the clean level. A level is accepted
    // once N+1 disagreeing samples arrive in a row (one to notice, N to qualify).
    logic        dq[$];
    logic        m_clean;
    int          run;
    int          m_dbn;
    int          m_rise;
    int          m_glitch;
    logic [31:0] m_rd;

    function automatic logic [1:0] m_code();
        if (!m_clean) return (run > 0) ? 2'd1 : 2'd0;
        else          return (run > 0) ? 2'd3 : 2'd2;
    endfunction

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < S; i++) dq.push_back(1'b0);
        m_clean  = 1'b0;
        run      = 0;
        m_dbn    = DEF_DBN;
        m_rise   = 0;
        m_glitch = 0;
        m_rd     = 32'd0;
    endtask

    task automatic tick();
        logic [31:0] rd;
        logic        samp;
        logic        wr;
        int          n;
        bit          rise_evt;
        bit          glitch_evt;
        case (address)
            2'd0:    rd = {28'd0, m_code(), dq[0], m_clean};
            2'd1:    rd = 32'(m_dbn);
            2'd2:    rd = 32'(m_rise);
            default: rd = GLITCH_EN ? 32'(m_glitch) : 32'd0;
        endcase
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            wr         = chipselect && !write_n;
            rise_evt   = 1'b0;
            glitch_evt = 1'b0;
            samp = dq.pop_front();
            dq.push_back(sensor_raw);
            n = (m_dbn == 0) ? 1 : m_dbn;
            if (wr && address == 2'd1 && run > 0) begin
                run = 0;
            end else if (samp != m_clean) begin
                run++;
                if (run == n + 1) begin
                    m_clean  = samp;
                    run      = 0;
                    rise_evt = samp;
                end
            end else if (run > 0) begin
                run        = 0;
                glitch_evt = 1'b1;
            end
            if (wr && address == 2'd2)            m_rise = 0;
            else if (rise_evt && m_rise < 65535) m_rise++;
            if (wr && address == 2'd3)              m_glitch = 0;
            else if (glitch_evt && m_glitch < 65535) m_glitch++;
            if (wr && address == 2'd1) m_dbn = int'(writedata[15:0]);
            m_rd = rd;
        end
        #1;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        address    = 2'd0;
    endtask

    // Counts cycles until sensor_clean reaches level; returns bound+1 on timeout.
    task automatic wait_clean(input logic level, input int bound, output int k);
        k = 0;
        while (sensor_clean !== level && k <= bound) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
        checks++;
        if (sensor_clean !== 1'b0) begin
            errors++; $display("FAIL reset_clean: got %0b want 0", sensor_clean);
        end
        checks++;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL reset_readdata: got %0h want 0", readdata);
        end
        address = 2'd1;
        tick();
        checks++;
        if (readdata !== 32'd1000) begin
            errors++; $display("FAIL reset_debounce: got %0d want 1000", readdata);
        end
        address = 2'd0;
        tick();
        checks++;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL reset_status: got %0h want 0", readdata);
        end
    endtask

    task automatic test_rise();
        int k;
        do_write(2'd1, 32'd4);
        settle(6);
        sensor_raw = 1'b1;
        tick();
        wait_clean(1'b1, 20, k);
        checks++;
        if (k !== 6) begin
            errors++; $display("FAIL rise_latency: got %0d cycles want 6", k);
        end
        checks++;
        if (sensor_clean !== m_clean) begin
            errors++; $display("FAIL rise_model: got %0b want %0b", sensor_clean, m_clean);
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'd1) begin
            errors++; $display("FAIL rise_cnt: got %0d want 1", readdata);
        end
        address    = 2'd0;
        sensor_raw = 1'b0;
        tick();
        wait_clean(1'b0, 20, k);
        checks++;
        if (k !== 6) begin
            errors++; $display("FAIL fall_latency: got %0d cycles want 6", k);
        end
    endtask

    task automatic test_glitch();
        do_write(2'd2, 32'd0);
        do_write(2'd3, 32'd0);
        settle(4);
        sensor_raw = 1'b1;
        settle(3);
        sensor_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (sensor_clean !== 1'b0) begin
                errors++; $display("FAIL glitch_clean: cycle %0d got %0b want 0", i, sensor_clean);
            end
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL glitch_rise_cnt: got %0d want 0", readdata);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== (GLITCH_EN ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL glitch_cnt: got %0d want %0d", readdata, GLITCH_EN);
        end
        address = 2'd0;
    endtask

    task automatic test_saturation();
        force dut.rise_cnt = 16'hFFFD;
        tick();
        release dut.rise_cnt;
        m_rise = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            sensor_raw = 1'b1;
            settle(10);
            sensor_raw = 1'b0;
            settle(10);
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'h0000FFFF) begin
            errors++; $display("FAIL rise_saturate: got %0h want ffff", readdata);
        end
        address    = 2'd0;
        sensor_raw = 1'b1;
        tick();
        settle(5);
        do_write(2'd2, 32'd0);
        checks++;
        if (sensor_clean !== 1'b1) begin
            errors++; $display("FAIL clear_race_clean: got %0b want 1", sensor_clean);
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'd0 || readdata !== m_rd) begin
            errors++; $display("FAIL clear_race_cnt: got %0d want 0", readdata);
        end
        address    = 2'd0;
        sensor_raw = 1'b0;
        settle(10);
    endtask

    task automatic test_n_zero();
        int k;
        do_write(2'd1, 32'd0);
        settle(4);
        sensor_raw = 1'b1;
        tick();
        wait_clean(1'b1, 20, k);
        checks++;
        if (k !== 3) begin
            errors++; $display("FAIL n0_rise_latency: got %0d want 3", k);
        end
        sensor_raw = 1'b0;
        tick();
        wait_clean(1'b0, 20, k);
        checks++;
        if (k !== 3) begin
            errors++; $display("FAIL n0_fall_latency: got %0d want 3", k);
        end
    endtask

    task automatic test_abort();
        int k;
        do_write(2'd1, 32'd8);
        settle(6);
        sensor_raw = 1'b1;
        tick();
        settle(7);
        checks++;
        if (readdata !== 32'h6) begin
            errors++; $display("FAIL abort_pre_status: got %0h want 6", readdata);
        end
        do_write(2'd1, 32'd8);
        tick();
        checks++;
        if (readdata !== 32'h2) begin
            errors++; $display("FAIL abort_status: got %0h want 2", readdata);
        end
        wait_clean(1'b1, 30, k);
        checks++;
        if (k !== 8) begin
            errors++; $display("FAIL abort_latency: got %0d want 8", k);
        end
        sensor_raw = 1'b0;
        settle(30);
    endtask

    task automatic test_reset_mid_chk();
        int k;
        sensor_raw = 1'b1;
        tick();
        settle(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (sensor_clean !== 1'b0 || readdata !== 32'd0) begin
            errors++; $display("FAIL midchk_reset: got clean %0b rd %0h want 0 0", sensor_clean, readdata);
        end
        tick();
        wait_clean(1'b1, 1100, k);
        checks++;
        if (k !== 1002) begin
            errors++; $display("FAIL midchk_latency: got %0d want 1002", k);
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'd1) begin
            errors++; $display("FAIL midchk_rise_cnt: got %0d want 1", readdata);
        end
        address    = 2'd0;
        sensor_raw = 1'b0;
        tick();
        wait_clean(1'b0, 1100, k);
        checks++;
        if (k !== 1002) begin
            errors++; $display("FAIL midchk_fall_latency: got %0d want 1002", k);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_write(2'd1, 32'($urandom_range(0, 5)));
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                sensor_raw = 1'($urandom_range(0, 1));
                hold       = $urandom_range(1, 9);
            end
            hold--;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 7) == 0);
            write_n    = !(chipselect && $urandom_range(0, 1) == 0);
            writedata  = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 5));
            tick();
            checks++;
            if (sensor_clean !== m_clean) begin
                errors++; $display("FAIL rand_clean: cycle %0d got %0b want %0b", i, sensor_clean, m_clean);
            end
            checks++;
            if (readdata !== m_rd) begin
                errors++; $display("FAIL rand_readdata: cycle %0d got %0h want %0h", i, readdata, m_rd);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise();
        test_glitch();
        test_saturation();
        test_n_zero();
        test_abort();
        test_reset_mid_chk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
